// File: rtl/led_blink_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel LED blinker.
package led_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    localparam int MODE_W = 2;

    // Counter width able to hold the largest terminal count, CLK_HZ itself.
    function automatic int cnt_w_f(input int unsigned clk_hz);
        return $clog2(clk_hz + 1);
    endfunction

    // Terminal count for a divider; only ever called with constant arguments
    // so the division is resolved at elaboration.
    function automatic int unsigned cnt_max_f(input int unsigned clk_hz,
                                              input int unsigned div,
                                              input int unsigned div_max);
        if (div == 0 || div > div_max)
            return clk_hz;
        return clk_hz / div;
    endfunction

endpackage

// File: rtl/led_blink_multi_if.sv
// Configuration write port, sync strobe and LED/tick outputs of led_blink_multi.
interface led_blink_multi_if #(
    parameter int NCH   = 4,
    parameter int DIV_W = 5
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             wr_en_i;
    logic [CH_W-1:0]  wr_ch_i;
    logic [DIV_W-1:0] wr_div_i;
    logic [1:0]       wr_mode_i;
    logic             wr_dim_i;
    logic             sync_i;
    logic [NCH-1:0]   led_o;
    logic [NCH-1:0]   tick_o;

    modport master (
        output wr_en_i, wr_ch_i, wr_div_i, wr_mode_i, wr_dim_i, sync_i,
        input  led_o, tick_o
    );

    modport slave (
        input  wr_en_i, wr_ch_i, wr_div_i, wr_mode_i, wr_dim_i, sync_i,
        output led_o, tick_o
    );

endinterface

// File: rtl/led_blink_chan.sv
// One LED channel: mode register, half-period counter, LED state and toggle tick.
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int          CNT_W  = 27
) (
    input  logic             clk100,
    input  logic             rst,
    input  logic             wr_i,
    input  mode_e            wr_mode_i,
    input  logic [CNT_W-1:0] wr_cnt_max_i,
    input  logic             sync_i,
    output logic             led_o,
    output logic             tick_o
);

    mode_e            mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_max_q;
    logic             led_q;
    logic             tick_q;

    // Priority: reset, then a write to this channel, then sync, then the mode itself.
    always_ff @(posedge clk100) begin
        if (rst) begin
            mode_q    <= MODE_OFF;
            cnt_q     <= '0;
            cnt_max_q <= CNT_W'(CLK_HZ);
            led_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (wr_i) begin
                mode_q    <= wr_mode_i;
                cnt_max_q <= wr_cnt_max_i;
                cnt_q     <= '0;
                led_q     <= (wr_mode_i != MODE_OFF);
            end else if (sync_i && mode_q == MODE_BLINK) begin
                cnt_q <= '0;
                led_q <= 1'b1;
            end else begin
                unique case (mode_q)
                    MODE_OFF: begin
                        cnt_q <= '0;
                        led_q <= 1'b0;
                    end
                    MODE_ON: begin
                        cnt_q <= '0;
                        led_q <= 1'b1;
                    end
                    MODE_BLINK: begin
                        if (cnt_q == cnt_max_q) begin
                            cnt_q  <= '0;
                            led_q  <= ~led_q;
                            tick_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    MODE_ONESHOT: begin
                        if (cnt_q == cnt_max_q) begin
                            cnt_q  <= '0;
                            led_q  <= 1'b0;
                            tick_q <= 1'b1;
                            mode_q <= MODE_OFF;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign led_o  = led_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker top: write decode, divider lookup, sync fan-out and
// the optional dimming prescaler enabled by defining LED_BLINK_DIM_EN.
module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter int          NCH     = 4,
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int          DIV_W   = 5,
    parameter int unsigned DIV_MAX = 20
) (
    input  logic             clk100,
    input  logic             rst,
    led_blink_multi_if.slave bus
);

    localparam int CNT_W = cnt_w_f(CLK_HZ);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NDIV  = 2 ** DIV_W;

    logic [CNT_W-1:0] cnt_tab [NDIV];
    logic [CNT_W-1:0] wr_cnt_max;
    logic             wr_ok;
    logic [NCH-1:0]   wr_hit;
    logic [NCH-1:0]   led_raw;
    logic [NCH-1:0]   led_drv;
    logic [NCH-1:0]   tick;

    // Every divider value maps to a constant terminal count; a write just indexes it.
    generate
        for (genvar gi = 0; gi < NDIV; gi++) begin : g_tab
            assign cnt_tab[gi] = CNT_W'(cnt_max_f(CLK_HZ, gi, DIV_MAX));
        end
    endgenerate

    assign wr_cnt_max = cnt_tab[bus.wr_div_i];
    assign wr_ok      = bus.wr_en_i && (int'(bus.wr_ch_i) < NCH);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign wr_hit[gi] = wr_ok && (bus.wr_ch_i == CH_W'(gi));

            led_blink_chan #(
                .CLK_HZ (CLK_HZ),
                .CNT_W  (CNT_W)
            ) u_chan (
                .clk100       (clk100),
                .rst          (rst),
                .wr_i         (wr_hit[gi]),
                .wr_mode_i    (mode_e'(bus.wr_mode_i)),
                .wr_cnt_max_i (wr_cnt_max),
                .sync_i       (bus.sync_i),
                .led_o        (led_raw[gi]),
                .tick_o       (tick[gi])
            );
        end
    endgenerate

`ifdef LED_BLINK_DIM_EN
    logic [1:0]     pre_q;
    logic [NCH-1:0] dim_q;

    always_ff @(posedge clk100) begin
        if (rst)
            pre_q <= 2'd0;
        else
            pre_q <= pre_q + 2'd1;
    end

    // Dimmed channels pass their LED state only in one prescaler slot out of four.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_dim
            always_ff @(posedge clk100) begin
                if (rst)
                    dim_q[gi] <= 1'b0;
                else if (wr_hit[gi])
                    dim_q[gi] <= bus.wr_dim_i;
            end
            assign led_drv[gi] = led_raw[gi] & (~dim_q[gi] | (pre_q == 2'd0));
        end
    endgenerate
`else
    logic unused_dim;
    assign unused_dim = bus.wr_dim_i;
    assign led_drv    = led_raw;
`endif

    assign bus.led_o  = led_drv;
    assign bus.tick_o = tick;

endmodule

// File: tb/tb_led_blink_multi.sv
// Directed self-checking bench for led_blink_multi (CLK_HZ=100, NCH=5 so that
// out-of-range channel numbers are representable on the 3-bit channel field).
module tb_led_blink_multi;

    localparam int NCH     = 5;
    localparam int CLK_HZ  = 100;
    localparam int DIV_W   = 5;
    localparam int DIV_MAX = 20;

    logic clk100 = 1'b0;
    logic rst    = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    led_blink_multi_if #(.NCH(NCH), .DIV_W(DIV_W)) bus ();

    led_blink_multi #(
        .NCH     (NCH),
        .CLK_HZ  (CLK_HZ),
        .DIV_W   (DIV_W),
        .DIV_MAX (DIV_MAX)
    ) dut (
        .clk100 (clk100),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 clk100 = ~clk100;

    task automatic drive_idle;
        bus.wr_en_i   = 1'b0;
        bus.wr_ch_i   = '0;
        bus.wr_div_i  = '0;
        bus.wr_mode_i = 2'd0;
        bus.wr_dim_i  = 1'b0;
        bus.sync_i    = 1'b0;
    endtask

    task automatic set_write(input int ch, input int div, input int mode, input int dim);
        bus.wr_en_i   = 1'b1;
        bus.wr_ch_i   = ch[2:0];
        bus.wr_div_i  = div[4:0];
        bus.wr_mode_i = mode[1:0];
        bus.wr_dim_i  = dim[0];
        $display("write ch=%0d div=%0d mode=%0d dim=%0d", ch, div, mode, dim);
    endtask

    // Returns at the falling edge right after the write edge (sample 0).
    task automatic write_ch(input int ch, input int div, input int mode, input int dim);
        @(negedge clk100);
        set_write(ch, div, mode, dim);
        @(negedge clk100);
        bus.wr_en_i = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk100);
        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk100);
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_reset;
        // Write attempted while reset is held must be ignored.
        rst = 1'b1;
        set_write(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk100);
            n_checks++;
            if (bus.led_o !== 5'b0 || bus.tick_o !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d led=%b tick=%b required 00000/00000", i, bus.led_o, bus.tick_o);
            end
        end
        rst = 1'b0;
        drive_idle();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk100);
            n_checks++;
            if (bus.led_o !== 5'b0 || bus.tick_o !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d led=%b tick=%b required 00000/00000", i, bus.led_o, bus.tick_o);
            end
        end
    endtask

    task automatic test_blink;
        logic [4:0] exp_led, exp_tick;
        do_reset();
        write_ch(1, 5, 2, 0);
        for (int s = 0; s <= 70; s++) begin
            if (s > 0) @(negedge clk100);
            exp_led  = (((s / 21) % 2) == 0) ? 5'b00010 : 5'b00000;
            exp_tick = (s > 0 && (s % 21) == 0) ? 5'b00010 : 5'b00000;
            n_checks++;
            if (bus.led_o !== exp_led || bus.tick_o !== exp_tick) begin
                n_fail++;
                $display("FAIL blink_div5 s=%0d led=%b tick=%b required %b/%b", s, bus.led_o, bus.tick_o, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_div_bounds;
        int         divs  [3] = '{0, 25, 20};
        int         halfs [3] = '{101, 101, 6};
        logic [4:0] exp_led, exp_tick;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            write_ch(0, divs[k], 2, 0);
            for (int s = 0; s <= 2 * halfs[k] + 1; s++) begin
                if (s > 0) @(negedge clk100);
                exp_led  = (((s / halfs[k]) % 2) == 0) ? 5'b00001 : 5'b00000;
                exp_tick = (s > 0 && (s % halfs[k]) == 0) ? 5'b00001 : 5'b00000;
                n_checks++;
                if (bus.led_o !== exp_led || bus.tick_o !== exp_tick) begin
                    n_fail++;
                    $display("FAIL div_bound div=%0d s=%0d led=%b tick=%b required %b/%b",
                             divs[k], s, bus.led_o, bus.tick_o, exp_led, exp_tick);
                end
            end
        end
    endtask

    task automatic test_oneshot;
        logic [4:0] exp_led, exp_tick;
        int         highs = 0;
        int         ticks = 0;
        do_reset();
        write_ch(2, 10, 3, 0);
        for (int s = 0; s <= 40; s++) begin
            if (s > 0) @(negedge clk100);
            exp_led  = (s <= 10) ? 5'b00100 : 5'b00000;
            exp_tick = (s == 11) ? 5'b00100 : 5'b00000;
            if (bus.led_o[2] === 1'b1) highs++;
            if (bus.tick_o[2] === 1'b1) ticks++;
            n_checks++;
            if (bus.led_o !== exp_led || bus.tick_o !== exp_tick) begin
                n_fail++;
                $display("FAIL oneshot s=%0d led=%b tick=%b required %b/%b", s, bus.led_o, bus.tick_o, exp_led, exp_tick);
            end
        end
        n_checks++;
        if (highs != 11 || ticks != 1) begin
            n_fail++;
            $display("FAIL oneshot_len high=%0d ticks=%0d required 11/1", highs, ticks);
        end
    endtask

    task automatic test_sync;
        logic [4:0] exp_led, exp_tick;
        do_reset();
        write_ch(0, 2, 2, 0);   // half-period 51
        write_ch(3, 4, 2, 0);   // half-period 26; ch0 now at sample 2
        repeat (57) @(negedge clk100);
        // ch0 at sample 59 (low phase), ch3 at sample 57 (high phase)
        n_checks++;
        if (bus.led_o !== 5'b01000) begin
            n_fail++;
            $display("FAIL sync_pre led=%b required 01000", bus.led_o);
        end
        set_write(3, 0, 1, 0);
        bus.sync_i = 1'b1;
        $display("sync with write ch=3");
        @(negedge clk100);
        drive_idle();
        for (int s = 0; s <= 60; s++) begin
            if (s > 0) @(negedge clk100);
            exp_led  = (s <= 50) ? 5'b01001 : 5'b01000;
            exp_tick = (s == 51) ? 5'b00001 : 5'b00000;
            n_checks++;
            if (bus.led_o !== exp_led || bus.tick_o !== exp_tick) begin
                n_fail++;
                $display("FAIL sync s=%0d led=%b tick=%b required %b/%b", s, bus.led_o, bus.tick_o, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] exp_led, exp_tick;
        do_reset();
        write_ch(4, 20, 2, 0);  // half-period 6
        repeat (2) @(negedge clk100);
        set_write(4, 20, 2, 0);
        @(negedge clk100);
        drive_idle();
        for (int s = 0; s <= 13; s++) begin
            if (s > 0) @(negedge clk100);
            exp_led  = (((s / 6) % 2) == 0) ? 5'b10000 : 5'b00000;
            exp_tick = (s == 6 || s == 12) ? 5'b10000 : 5'b00000;
            n_checks++;
            if (bus.led_o !== exp_led || bus.tick_o !== exp_tick) begin
                n_fail++;
                $display("FAIL rewrite s=%0d led=%b tick=%b required %b/%b", s, bus.led_o, bus.tick_o, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_bad_channel;
        do_reset();
        write_ch(1, 0, 1, 0);
        write_ch(5, 0, 1, 0);
        write_ch(7, 3, 2, 0);
        for (int s = 0; s < 20; s++) begin
            if (s > 0) @(negedge clk100);
            n_checks++;
            if (bus.led_o !== 5'b00010 || bus.tick_o !== 5'b00000) begin
                n_fail++;
                $display("FAIL bad_channel s=%0d led=%b tick=%b required 00010/00000", s, bus.led_o, bus.tick_o);
            end
        end
    endtask

    task automatic test_dim;
        do_reset();
        write_ch(0, 0, 1, 1);
        write_ch(1, 0, 1, 0);
`ifdef LED_BLINK_DIM_EN
        begin
            int first = -1;
            int highs = 0;
            logic [39:0] seen;
            for (int s = 0; s < 40; s++) begin
                if (s > 0) @(negedge clk100);
                seen[s] = bus.led_o[0];
                if (bus.led_o[0] === 1'b1) begin
                    highs++;
                    if (first < 0) first = s;
                end
                n_checks++;
                if (bus.led_o[1] !== 1'b1 || bus.tick_o !== 5'b0) begin
                    n_fail++;
                    $display("FAIL dim_undimmed s=%0d led=%b tick=%b required led[1]=1 tick=00000", s, bus.led_o, bus.tick_o);
                end
            end
            n_checks++;
            if (highs != 10 || first < 0 || first > 3) begin
                n_fail++;
                $display("FAIL dim_duty highs=%0d first=%0d required 10 highs, first<4", highs, first);
            end else begin
                for (int s = 0; s < 40; s++) begin
                    n_checks++;
                    if (seen[s] !== ((s % 4) == first)) begin
                        n_fail++;
                        $display("FAIL dim_phase s=%0d led0=%b required %b", s, seen[s], ((s % 4) == first));
                    end
                end
            end
        end
`else
        for (int s = 0; s < 20; s++) begin
            if (s > 0) @(negedge clk100);
            n_checks++;
            if (bus.led_o !== 5'b00011 || bus.tick_o !== 5'b00000) begin
                n_fail++;
                $display("FAIL dim_ignored s=%0d led=%b tick=%b required 00011/00000", s, bus.led_o, bus.tick_o);
            end
        end
`endif
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_blink();
        test_div_bounds();
        test_oneshot();
        test_sync();
        test_back_to_back();
        test_bad_channel();
        test_dim();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
